// File: rtl/card_pkg.sv
// Shared types and constants for the blackjack card datapath.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  localparam int          MAX_CARDS = 9;
  localparam logic [3:0]  MAX_COUNT = 4'd9;

  // Which hand a draw is aimed at.
  localparam logic TGT_PLAYER = 1'b0;
  localparam logic TGT_DEALER = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_DONE
  } dealer_state_t;

  // A raw 4-bit draw is a playable card only when it is Ace..King.
  function automatic logic card_valid(input card_t c);
    return (c >= CARD_ACE) && (c <= CARD_KING);
  endfunction

endpackage

// File: rtl/SM_if.sv
// Hand slot bundle between the card dealer and the hand value calculator.
interface SM_if;
  card_pkg::card_t player_card_values [0:8];
  card_pkg::card_t dealer_card_values [0:8];

  modport out (output player_card_values, output dealer_card_values);
  modport in  (input  player_card_values, input  dealer_card_values);
endinterface

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR (right shift, mask B400) used as the card source.
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  localparam logic [15:0] MASK = 16'hB400;

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next value: shift right, fold the mask back in when a one falls out.
  always_comb begin
    state_d = state_q >> 1;
    if (state_q[0]) begin
      state_d = state_d ^ MASK;
    end
  end

  // State register; only advances when asked to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (step) begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: clears and deals P,D,P,D on a new round, adds single cards on
// hits, and exposes both hands as registered slots for the value calculator.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter bit          FREE_RUN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_start,
  input  logic       player_hit,
  input  logic       dealer_hit,
  output logic       busy,
  output logic       done,
  output logic       hand_full,
  output logic [3:0] player_card_count,
  output logic [3:0] dealer_card_count,
  SM_if.out          card_if
);

  dealer_state_t state_q, state_d;
  logic          target_q, target_d;
  logic          is_deal_q, is_deal_d;
  logic [1:0]    accepts_q, accepts_d;
  logic          full_q, full_d;
  logic [3:0]    pcount_q, pcount_d;
  logic [3:0]    dcount_q, dcount_d;

  logic [15:0]   lfsr_state;
  logic          lfsr_step;
  logic          lfsr_unused;
  card_t         cand;
  logic          clear_en;
  logic          wr_player;
  logic          wr_dealer;

  // In deterministic mode the sequence only moves while drawing, so a given
  // seed always produces the same hands regardless of idle time.
  assign lfsr_step = FREE_RUN ? 1'b1 : (state_q == ST_DRAW);

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Only the low nibble is a card candidate; the rest is LFSR history.
  assign cand        = lfsr_state[3:0];
  assign lfsr_unused = ^lfsr_state[15:4];

  // Control state and hand counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= TGT_PLAYER;
      is_deal_q <= 1'b0;
      accepts_q <= 2'd0;
      full_q    <= 1'b0;
      pcount_q  <= 4'd0;
      dcount_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      is_deal_q <= is_deal_d;
      accepts_q <= accepts_d;
      full_q    <= full_d;
      pcount_q  <= pcount_d;
      dcount_q  <= dcount_d;
    end
  end

  // Next-state, slot write enables and status outputs.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    is_deal_d = is_deal_q;
    accepts_d = accepts_q;
    full_d    = full_q;
    pcount_d  = pcount_q;
    dcount_d  = dcount_q;
    clear_en  = 1'b0;
    wr_player = 1'b0;
    wr_dealer = 1'b0;
    done      = 1'b0;
    hand_full = 1'b0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        full_d = 1'b0;
        if (deal_start) begin
          is_deal_d = 1'b1;
          state_d   = ST_CLEAR;
        end else if (player_hit) begin
          is_deal_d = 1'b0;
          target_d  = TGT_PLAYER;
          if (pcount_q >= MAX_COUNT) begin
            full_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAW;
          end
        end else if (dealer_hit) begin
          is_deal_d = 1'b0;
          target_d  = TGT_DEALER;
          if (dcount_q >= MAX_COUNT) begin
            full_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end

      ST_CLEAR: begin
        clear_en  = 1'b1;
        pcount_d  = 4'd0;
        dcount_d  = 4'd0;
        target_d  = TGT_PLAYER;
        accepts_d = 2'd0;
        state_d   = ST_DRAW;
      end

      ST_DRAW: begin
        // A rejected candidate simply costs this cycle; the LFSR has moved on.
        if (card_valid(cand)) begin
          if (target_q == TGT_PLAYER) begin
            wr_player = (pcount_q < MAX_COUNT);
            if (wr_player) pcount_d = pcount_q + 4'd1;
          end else begin
            wr_dealer = (dcount_q < MAX_COUNT);
            if (wr_dealer) dcount_d = dcount_q + 4'd1;
          end
          if (is_deal_q) begin
            accepts_d = accepts_q + 2'd1;
            target_d  = ~target_q;
            if (accepts_q == 2'd3) state_d = ST_DONE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done      = 1'b1;
        hand_full = full_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign player_card_count = pcount_q;
  assign dealer_card_count = dcount_q;

  // One register per slot: written only when it is the next free slot of the
  // targeted hand, so the other hand and higher slots are never disturbed.
  for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
    card_t pslot_q;
    card_t dslot_q;

    // Player and dealer slot gi.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pslot_q <= CARD_EMPTY;
        dslot_q <= CARD_EMPTY;
      end else if (clear_en) begin
        pslot_q <= CARD_EMPTY;
        dslot_q <= CARD_EMPTY;
      end else begin
        if (wr_player && (pcount_q == 4'(gi))) pslot_q <= cand;
        if (wr_dealer && (dcount_q == 4'(gi))) dslot_q <= cand;
      end
    end

    assign card_if.player_card_values[gi] = pslot_q;
    assign card_if.dealer_card_values[gi] = dslot_q;
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer (FREE_RUN=0, SEED=ACE1): a phase-list
// model of each request is compared against the DUT every cycle, plus fixed
// expectations for the known first deal.
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  localparam int K_CLEAR = 0;
  localparam int K_DRAW  = 1;
  localparam int K_DONE  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal_start;
  logic       player_hit;
  logic       dealer_hit;
  logic       busy;
  logic       done;
  logic       hand_full;
  logic [3:0] pcnt;
  logic [3:0] dcnt;

  SM_if card_if_inst ();

  card_dealer #(.SEED(SEED), .FREE_RUN(1'b0)) dut (
    .clk               (clk),
    .rst               (rst),
    .deal_start        (deal_start),
    .player_hit        (player_hit),
    .dealer_hit        (dealer_hit),
    .busy              (busy),
    .done              (done),
    .hand_full         (hand_full),
    .player_card_count (pcnt),
    .dealer_card_count (dcnt),
    .card_if           (card_if_inst)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted request becomes a list of cycle phases (CLEAR, DRAW..., DONE).
  // The head phase is what the DUT should be showing; its effect lands on the
  // clock edge that retires it.
  typedef struct {
    int kind;
    bit wr;
    bit tgt;
    int val;
    bit full;
  } phase_t;

  phase_t      plan[$];
  int          m_player[9];
  int          m_dealer[9];
  int          m_pc;
  int          m_dc;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic lsb;
    logic [15:0] r;
    lsb = s[0];
    r = s >> 1;
    if (lsb) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic m_reset();
    plan.delete();
    for (int i = 0; i < 9; i++) begin
      m_player[i] = 0;
      m_dealer[i] = 0;
    end
    m_pc = 0;
    m_dc = 0;
    m_lfsr = SEED;
  endtask

  // Pull candidates until n cards are accepted; each candidate costs a cycle.
  task automatic plan_draws(input int n, input bit alternate, input bit first_tgt);
    int got;
    bit t;
    got = 0;
    t = first_tgt;
    while (got < n) begin
      int c;
      phase_t p;
      c = int'(m_lfsr[3:0]);
      m_lfsr = lfsr_adv(m_lfsr);
      p.kind = K_DRAW;
      p.full = 1'b0;
      p.tgt = t;
      if (c >= 1 && c <= 13) begin
        p.wr = 1'b1;
        p.val = c;
        got++;
        if (alternate) t = ~t;
      end else begin
        p.wr = 1'b0;
        p.val = 0;
      end
      plan.push_back(p);
    end
  endtask

  task automatic push_done(input bit full);
    phase_t p;
    p.kind = K_DONE;
    p.wr = 1'b0;
    p.tgt = 1'b0;
    p.val = 0;
    p.full = full;
    plan.push_back(p);
  endtask

  task automatic m_step();
    if (plan.size() != 0) begin
      phase_t p;
      p = plan.pop_front();
      if (p.kind == K_CLEAR) begin
        for (int i = 0; i < 9; i++) begin
          m_player[i] = 0;
          m_dealer[i] = 0;
        end
        m_pc = 0;
        m_dc = 0;
      end else if (p.kind == K_DRAW && p.wr) begin
        if (p.tgt == 1'b0) begin
          m_player[m_pc] = p.val;
          m_pc++;
        end else begin
          m_dealer[m_dc] = p.val;
          m_dc++;
        end
      end
    end else if (deal_start) begin
      phase_t c;
      c.kind = K_CLEAR;
      c.wr = 1'b0;
      c.tgt = 1'b0;
      c.val = 0;
      c.full = 1'b0;
      plan.push_back(c);
      plan_draws(4, 1'b1, 1'b0);
      push_done(1'b0);
    end else if (player_hit) begin
      if (m_pc == 9) push_done(1'b1);
      else begin
        plan_draws(1, 1'b0, 1'b0);
        push_done(1'b0);
      end
    end else if (dealer_hit) begin
      if (m_dc == 9) push_done(1'b1);
      else begin
        plan_draws(1, 1'b0, 1'b1);
        push_done(1'b0);
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      bit eb;
      bit ed;
      bit ef;
      @(negedge clk);
      eb = (plan.size() != 0);
      ed = eb && (plan[0].kind == K_DONE);
      ef = ed && plan[0].full;
      check("busy", busy, eb);
      check("done", done, ed);
      check("hand_full", hand_full, ef);
      check("player_count", pcnt, m_pc);
      check("dealer_count", dcnt, m_dc);
      for (int i = 0; i < 9; i++) begin
        check($sformatf("pslot%0d", i), card_if_inst.player_card_values[i], m_player[i]);
        check($sformatf("dslot%0d", i), card_if_inst.dealer_card_values[i], m_dealer[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input bit d, input bit p, input bit q);
    @(negedge clk);
    deal_start = d;
    player_hit = p;
    dealer_hit = q;
    @(negedge clk);
    deal_start = 1'b0;
    player_hit = 1'b0;
    dealer_hit = 1'b0;
  endtask

  // Returns the number of edges after the request edge at which done shows.
  task automatic wait_done(output int edges, output logic hf);
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    hf = hand_full;
    check("done_seen", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pcnt"}, pcnt, 0);
    check({tag, "_dcnt"}, dcnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_full"}, hand_full, 0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s_p%0d", tag, i), card_if_inst.player_card_values[i], 0);
      check($sformatf("%s_d%0d", tag, i), card_if_inst.dealer_card_values[i], 0);
    end
  endtask

  // Blackjack total of a hand read from the DUT slots (aces soft).
  function automatic int bj_total(input bit dealer);
    int t;
    int aces;
    int v;
    t = 0;
    aces = 0;
    for (int i = 0; i < 9; i++) begin
      v = dealer ? int'(card_if_inst.dealer_card_values[i])
                 : int'(card_if_inst.player_card_values[i]);
      if (v == 1) begin
        aces++;
        t += 11;
      end else if (v >= 10) t += 10;
      else t += v;
    end
    while (t > 21 && aces > 0) begin
      t -= 10;
      aces--;
    end
    return t;
  endfunction

  // Seed ACE1 draws 1, rej, 8, 12, rej, 7: player {1,12}, dealer {8,7}.
  task automatic check_first_hand(input string tag);
    check({tag, "_p0"}, card_if_inst.player_card_values[0], 1);
    check({tag, "_p1"}, card_if_inst.player_card_values[1], 12);
    check({tag, "_p2"}, card_if_inst.player_card_values[2], 0);
    check({tag, "_d0"}, card_if_inst.dealer_card_values[0], 8);
    check({tag, "_d1"}, card_if_inst.dealer_card_values[1], 7);
    check({tag, "_d2"}, card_if_inst.dealer_card_values[2], 0);
    check({tag, "_pcnt"}, pcnt, 2);
    check({tag, "_dcnt"}, dcnt, 2);
    check({tag, "_ptotal"}, bj_total(1'b0), 21);
    check({tag, "_dtotal"}, bj_total(1'b1), 15);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   lat;
    logic hf;
    int   k;
    logic [3:0] snap[9];

    rst = 1'b1;
    deal_start = 1'b0;
    player_hit = 1'b0;
    dealer_hit = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // First deal: 6 DRAW cycles, done visible after edge N+7 (cycle N+8).
    pulse(1'b1, 1'b0, 1'b0);
    wait_done(lat, hf);
    check("deal_latency", lat, 7);
    check("deal_hf", hf, 0);
    check_first_hand("deal1");

    // Player hit: next state B313 gives a 3 at once.
    pulse(1'b0, 1'b1, 1'b0);
    wait_done(lat, hf);
    check("hit_latency", lat, 1);
    check("hit_p2", card_if_inst.player_card_values[2], 3);
    check("hit_pcnt", pcnt, 3);
    check("hit_d0", card_if_inst.dealer_card_values[0], 8);
    check("hit_d1", card_if_inst.dealer_card_values[1], 7);

    // Both hits together: player wins.
    pulse(1'b0, 1'b1, 1'b1);
    wait_done(lat, hf);
    check("both_pcnt", pcnt, 4);
    check("both_dcnt", dcnt, 2);

    // Fill the player hand, then one more hit must report full.
    k = 0;
    while (pcnt != 4'd9 && k < 12) begin
      pulse(1'b0, 1'b1, 1'b0);
      wait_done(lat, hf);
      k++;
    end
    check("filled_pcnt", pcnt, 9);
    for (int i = 0; i < 9; i++) snap[i] = card_if_inst.player_card_values[i];
    pulse(1'b0, 1'b1, 1'b0);
    wait_done(lat, hf);
    check("full_latency", lat, 0);
    check("full_flag", hf, 1);
    @(negedge clk);
    check("full_pcnt", pcnt, 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("full_keep_p%0d", i), card_if_inst.player_card_values[i], snap[i]);

    // Dealer hit still works and full the dealer hand too.
    k = 0;
    while (dcnt != 4'd9 && k < 12) begin
      pulse(1'b0, 1'b0, 1'b1);
      wait_done(lat, hf);
      k++;
    end
    pulse(1'b0, 1'b0, 1'b1);
    wait_done(lat, hf);
    check("dfull_flag", hf, 1);

    // Requests while busy are dropped.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    pulse(1'b1, 1'b1, 1'b1);
    wait_done(lat, hf);
    check_first_hand("busyign");

    // Reset right after the first slot write.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    k = 0;
    while (pcnt != 4'd1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_write_seen", pcnt, 1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    wait_done(lat, hf);
    check("redeal_latency", lat, 7);
    check_first_hand("redeal");

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = 1'b0;
      deal_start = ($urandom_range(0, 29) == 0);
      player_hit = ($urandom_range(0, 3) == 0);
      dealer_hit = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 check("rnd_rst_pcnt", pcnt, 0);
        check("rnd_rst_dcnt", dcnt, 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    deal_start = 1'b0;
    player_hit = 1'b0;
    dealer_hit = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
